dram_port_arbiter: RTL
======================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single dummy-DRAM port between NUM_REQ cache-side requesters
//  (e.g. I-cache miss refill, D-cache miss refill, D-cache SW write-through).
//  Sits between the cache controllers and the DRAM.
//  Round-robin arbitration; the grant is locked for the whole req/ready transaction.
//  Captures the winner's command and returns read data plus a one-cycle done pulse.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..4)
//  DATA_W   32  DRAM data width, matches cache `data`
//  TMO_CYC  64  timeout cycles (used only with DRAM_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1              clock, all logic on posedge
//  rst         in   1              asynchronous, active-low reset
//  req         in   NUM_REQ        per-requester request level
//  req_op      in   NUM_REQ x lsu_ops  per-requester LW (read) / SW (write)
//  req_addr    in   NUM_REQ x 32   per-requester address
//  req_wdata   in   NUM_REQ x DATA_W  per-requester write data
//  gnt         out  NUM_REQ        one-hot; current owner, high for the whole transaction
//  done        out  NUM_REQ        one-hot, one-cycle pulse on completion
//  rdata       out  DATA_W         read data; valid with done
//  err         out  1              one-cycle pulse on timeout (DRAM_ARB_TIMEOUT_EN only)
//  mem_req     out  1              request to DRAM
//  mem_op      out  lsu_ops        registered op
//  mem_addr    out  32             registered address
//  mem_wdata   out  DATA_W         registered write data
//  mem_ready   in   1              DRAM completion strobe
//  mem_rdata   in   DATA_W         DRAM read data, valid with mem_ready
// BEHAVIOUR
//  Reset values
//   All outputs 0, mem_op=LW, state IDLE, rr_ptr=0.
//  Requester rule
//   Raise req, hold op/addr/wdata stable until done.
//   Drop req in the cycle after done.
//   Dropping req before done is illegal.
//  FSM states
//   IDLE: if any req is set, pick the first set bit at or after rr_ptr (wrapping).
//     Register owner, op, addr and wdata. Set gnt[owner]=1 and mem_req=1. Next state BUSY.
//     Grant latency: req sampled at edge N -> gnt and mem_req high after edge N+1.
//   BUSY: mem_req and gnt are held.
//     On mem_ready=1: done[owner]=1 for one cycle; rdata<=mem_rdata on LW, else unchanged.
//     Also on mem_ready=1: mem_req<=0, gnt<=0, rr_ptr<=owner+1 (mod NUM_REQ). Next state RELEASE.
//   RELEASE: one dead cycle so the owner can drop req. No grant issued. Next state IDLE.
//   Minimum back-to-back transaction period: 3 cycles (IDLE, BUSY with ready, RELEASE).
//  Boundary conditions
//   mem_ready while IDLE/RELEASE: ignored.
//   mem_ready in the same cycle as entering BUSY: not possible, since ready is sampled only in BUSY.
//   All req set: strict rotation, 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
//   rr_ptr wrap: pointer at NUM_REQ-1 plus 1 gives 0.
//   Reset asserted mid-BUSY: immediate return to IDLE, mem_req=0, gnt=0, no done.
//     The DRAM model must tolerate the abandoned transaction.
//   req bits outside the owner changing during BUSY: no effect.
// CONFIGURATION
//  DRAM_ARB_TIMEOUT_EN defined
//   A counter clears on entering BUSY and counts each BUSY cycle.
//   If it reaches TMO_CYC without mem_ready: err=1 and done[owner]=1 for one cycle, rdata unchanged.
//   Then mem_req=0 and state goes to RELEASE; rr_ptr advances normally.
//  DRAM_ARB_TIMEOUT_EN undefined
//   No counter. err is tied to 0. BUSY waits indefinitely.
// STRUCTURE
//  cache_pkg: arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RELEASE} (2-bit).
//  cache_pkg: localparam DRAM_ARB_MAX_REQ=4. Reuse the existing lsu_ops.
//  Sub-module rr_pick #(NUM_REQ): combinational.
//   Inputs: req vector, rr_ptr. Outputs: one-hot winner, winner index, any_req.
//  The top owns the FSM, the capture registers and the optional timeout counter.
// TESTING
//  1 Single read: req[0] with LW, addr 0x100; ready 4 cycles after mem_req, rdata 0xDEADBEEF.
//    -> gnt[0] set 1 cycle after req, mem_addr=0x100, done[0] pulse, rdata=0xDEADBEEF.
//  2 Contention: req[0] and req[1] set together from reset.
//    -> grant order 0,1,0,1 over 4 transactions. No overlap of gnt. RELEASE gap of 1 cycle each.
//  3 Write path: req[1] with SW, wdata 0x12345678.
//    -> mem_op=SW and mem_wdata=0x12345678 held until ready. done[1] pulses. rdata unchanged.
//  4 Stray ready: mem_ready pulsed in IDLE, then a normal read.
//    -> no done from the stray pulse; the read completes normally.
//  5 Reset mid-BUSY: rst low 2 cycles after mem_req rises.
//    -> mem_req, gnt and done all 0 immediately. Next req is granted cleanly from rr_ptr=0.
//  6 With DRAM_ARB_TIMEOUT_EN and TMO_CYC=8, ready never asserted.
//    -> err and done[owner] pulse after 8 BUSY cycles. The other requester is granted next.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-subsystem types: LSU op encoding and DRAM port arbiter state.
package cache_pkg;

  typedef enum logic {
    LW = 1'b0,
    SW = 1'b1
  } lsu_ops;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned DRAM_ARB_MAX_REQ = 4;

endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IdxW-1:0]    winner_idx_o,
  output logic               any_req_o
);

  always_comb begin
    int unsigned idx;
    winner_oh_o  = '0;
    winner_idx_o = '0;
    any_req_o    = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o         = 1'b1;
        winner_oh_o[idx]  = 1'b1;
        winner_idx_o      = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM port among cache requesters; grant held per transaction.
// Optional BUSY timeout enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_port_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  lsu_ops [NUM_REQ-1:0]           req_op,
  input  logic [NUM_REQ-1:0][31:0]       req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_W-1:0]              rdata,
  output logic                           err,
  output logic                           mem_req,
  output lsu_ops                         mem_op,
  output logic [31:0]                    mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_ready,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  lsu_ops              mem_op_q, mem_op_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]  win_oh;
  logic [IdxW-1:0]     win_idx;
  logic                any_req;
  logic                timeout;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (win_oh),
    .winner_idx_o (win_idx),
    .any_req_o    (any_req)
  );

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;

  // Counter is zero in the first BUSY cycle, so the last allowed cycle sees TMO_CYC-1.
  assign timeout = (state_q == ARB_BUSY) && !mem_ready && (tmo_cnt_q == TmoW'(TMO_CYC - 1));
  assign err_d   = timeout;
  assign err     = err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ARB_BUSY) begin
      tmo_cnt_d = '0;
    end else if (!timeout) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d     = win_idx;
          gnt_d       = win_oh;
          mem_req_d   = 1'b1;
          mem_op_d    = req_op[win_idx];
          mem_addr_d  = req_addr[win_idx];
          mem_wdata_d = req_wdata[win_idx];
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ready || timeout) begin
          done_d = gnt_q;
          if (mem_ready && (mem_op_q == LW)) begin
            rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          gnt_d     = '0;
          rr_ptr_d  = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
          state_d   = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_op_q    <= LW;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
